// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, ALU codes, state encodings, mux selects.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mc_ctrl_pkg;

   // Opcode field values (IR[31:26])
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   // ALU function codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;

   // PC source select
   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_RS  = 2'b10;
   localparam logic [1:0] PC_JMP = 2'b11;

   // Write-register select
   localparam logic [1:0] RO_RA = 2'b00;
   localparam logic [1:0] RO_RT = 2'b01;
   localparam logic [1:0] RO_RD = 2'b10;

   typedef enum logic [3:0] {
      S_IF     = 4'b0000,
      S_ID     = 4'b0001,
      S_EXE_LS = 4'b0010,
      S_MEM    = 4'b0011,
      S_WB_LW  = 4'b0100,
      S_EXE_BR = 4'b0101,
      S_EXE_R  = 4'b0110,
      S_WB_R   = 4'b0111,
      S_HALT   = 4'b1000,
      S_FAULT  = 4'b1001
   } state_t;

   // Immediate-operand ALU instructions (write rt, take the extended immediate)
   function automatic logic is_imm(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_ORI);
   endfunction

   // ALU function for the instructions that pass through EXE_R
   function automatic logic [2:0] alu_for(input logic [5:0] op);
      logic [2:0] f;
      f = ALU_ADD;
      case (op)
         OP_SUB:         f = ALU_SUB;
         OP_OR, OP_ORI:  f = ALU_OR;
         OP_AND:         f = ALU_AND;
         OP_SLT:         f = ALU_SLT;
         default:        f = ALU_ADD;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating count of consecutive not-ready cycles; flags when the count sits at MAX_WAIT.
// Latency: count updates one cycle after wait_inc; timeout is combinational from the count.
// Backpressure: none; clears whenever wait_inc is low, saturates (never wraps) while high.
// Ports: clk, rst_n (async active-low), wait_inc (waiting this cycle), timeout (count == MAX_WAIT).
module mc_wait_timer
   import mc_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_inc,
   output logic timeout
);

   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

   logic [CW-1:0] wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!wait_inc) begin
         wait_cnt <= '0;
      end else if (wait_cnt != CNT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Reported regardless of ready so the FSM can let a same-cycle ready win.
   assign timeout = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU controller: IF/ID/EXE/MEM/WB sequencing with ready-handshake memories, timeout FAULT, HALT.
// Latency: outputs combinational from state/opcode/zero; state advances one step per CLK.
// Backpressure: IF/MEM hold while imem_ready/dmem_ready low; MAX_WAIT+1 idle cycles -> sticky FAULT.
// Optional: define MC_PERF_CNT_EN to add cycle_cnt/instr_cnt outputs.
// Ports: CLK, Reset (async active-low); opcode, zero, imem_ready, dmem_ready in;
//        memory requests, datapath enables/selects, ALUOp, state, fault, halted out.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 3,
   parameter int STATE_W  = 4,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                PCWre,
   output logic                IRWre,
   output logic                RegWre,
   output logic                DataMemRW,
   output logic                ALUSrcB,
   output logic                ExtSel,
   output logic [1:0]          RegOut,
   output logic                ALUM2Reg,
   output logic                WrRegData,
   output logic [1:0]          PCSrc,
   output logic [ALUOP_W-1:0]  ALUOp,
   output logic [STATE_W-1:0]  state,
   output logic                fault,
`ifdef MC_PERF_CNT_EN
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    instr_cnt,
`endif
   output logic                halted
);

   state_t     cur_state;
   state_t     nxt_state;
   logic [5:0] op;
   logic [2:0] alu;
   logic       wait_inc;
   logic       timeout;

   assign op    = 6'(opcode);
   assign ALUOp = ALUOP_W'(alu);
   assign state = STATE_W'(cur_state);

   mc_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk      (CLK),
      .rst_n    (Reset),
      .wait_inc (wait_inc),
      .timeout  (timeout)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cur_state <= S_IF;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      wait_inc  = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      DataMemRW = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      RegOut    = RO_RA;
      ALUM2Reg  = 1'b0;
      WrRegData = 1'b0;
      PCSrc     = PC_SEQ;
      alu       = ALU_ADD;
      fault     = 1'b0;
      halted    = 1'b0;

      // Outputs are gated by Reset so requests drop the instant reset asserts,
      // not at the next edge.
      if (Reset) begin
         case (cur_state)
            S_IF: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  IRWre     = 1'b1;
                  nxt_state = S_ID;
               end else begin
                  wait_inc = 1'b1;
                  if (timeout) nxt_state = S_FAULT;
               end
            end

            S_ID: begin
               case (op)
                  OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT, OP_ADDI, OP_ORI:
                     nxt_state = S_EXE_R;
                  OP_BEQ:
                     nxt_state = S_EXE_BR;
                  OP_LW, OP_SW:
                     nxt_state = S_EXE_LS;
                  OP_J: begin
                     PCSrc     = PC_JMP;
                     PCWre     = 1'b1;
                     nxt_state = S_IF;
                  end
                  OP_JR: begin
                     PCSrc     = PC_RS;
                     PCWre     = 1'b1;
                     nxt_state = S_IF;
                  end
                  OP_JAL: begin
                     // Link: PC+4 into ra
                     RegOut    = RO_RA;
                     WrRegData = 1'b0;
                     RegWre    = 1'b1;
                     PCSrc     = PC_JMP;
                     PCWre     = 1'b1;
                     nxt_state = S_IF;
                  end
                  OP_HALT:
                     nxt_state = S_HALT;
                  default:
                     nxt_state = S_FAULT;
               endcase
            end

            S_EXE_R: begin
               alu       = alu_for(op);
               ALUSrcB   = is_imm(op);
               ExtSel    = (op != OP_ORI);
               nxt_state = S_WB_R;
            end

            S_WB_R: begin
               RegWre    = 1'b1;
               RegOut    = is_imm(op) ? RO_RT : RO_RD;
               WrRegData = 1'b1;
               PCWre     = 1'b1;
               PCSrc     = PC_SEQ;
               nxt_state = S_IF;
            end

            S_EXE_BR: begin
               alu       = ALU_SUB;
               PCWre     = 1'b1;
               PCSrc     = zero ? PC_BR : PC_SEQ;
               nxt_state = S_IF;
            end

            S_EXE_LS: begin
               alu       = ALU_ADD;
               ALUSrcB   = 1'b1;
               ExtSel    = 1'b1;
               nxt_state = S_MEM;
            end

            S_MEM: begin
               dmem_req  = 1'b1;
               DataMemRW = (op == OP_SW);
               if (dmem_ready) begin
                  if (op == OP_SW) begin
                     PCWre     = 1'b1;
                     nxt_state = S_IF;
                  end else begin
                     nxt_state = S_WB_LW;
                  end
               end else begin
                  wait_inc = 1'b1;
                  if (timeout) nxt_state = S_FAULT;
               end
            end

            S_WB_LW: begin
               RegWre    = 1'b1;
               RegOut    = RO_RT;
               ALUM2Reg  = 1'b1;
               WrRegData = 1'b1;
               PCWre     = 1'b1;
               nxt_state = S_IF;
            end

            S_HALT: begin
               halted    = 1'b1;
               nxt_state = S_HALT;
            end

            S_FAULT: begin
               fault     = 1'b1;
               nxt_state = S_FAULT;
            end

            // Unused encodings are treated as corruption.
            default: nxt_state = S_FAULT;
         endcase
      end
   end

`ifdef MC_PERF_CNT_EN
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (cur_state != S_HALT && cur_state != S_FAULT) cycle_cnt <= cycle_cnt + 1'b1;
         if (PCWre) instr_cnt <= instr_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: stimulus pushes hand-computed per-cycle outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
// Latency/backpressure: one expectation per clock cycle, checked mid-cycle.
module tb_mc_ctrl_fsm;

   localparam logic [5:0] T_ADD  = 6'b000000;
   localparam logic [5:0] T_SLT  = 6'b100110;
   localparam logic [5:0] T_ORI  = 6'b010010;
   localparam logic [5:0] T_SW   = 6'b110000;
   localparam logic [5:0] T_LW   = 6'b110001;
   localparam logic [5:0] T_BEQ  = 6'b110100;
   localparam logic [5:0] T_J    = 6'b111000;
   localparam logic [5:0] T_JR   = 6'b111001;
   localparam logic [5:0] T_JAL  = 6'b111010;
   localparam logic [5:0] T_HALT = 6'b111111;
   localparam logic [5:0] T_BAD  = 6'b101010;

   localparam logic [3:0] Q_IF = 4'b0000, Q_ID = 4'b0001, Q_EXE_R = 4'b0110, Q_EXE_BR = 4'b0101;
   localparam logic [3:0] Q_EXE_LS = 4'b0010, Q_MEM = 4'b0011, Q_WB_R = 4'b0111, Q_WB_LW = 4'b0100;
   localparam logic [3:0] Q_HALT = 4'b1000, Q_FAULT = 4'b1001;

   typedef struct packed {
      logic [3:0] st;
      logic       imem_req;
      logic       dmem_req;
      logic       pcwre;
      logic       irwre;
      logic       regwre;
      logic       memrw;
      logic       alusrcb;
      logic       extsel;
      logic [1:0] regout;
      logic       alum2reg;
      logic       wrregdata;
      logic [1:0] pcsrc;
      logic [2:0] aluop;
      logic       fault;
      logic       halted;
   } obs_t;

   logic       CLK;
   logic       Reset;
   logic [5:0] opcode;
   logic       zero;
   logic       imem_ready;
   logic       dmem_ready;
   logic       imem_req, dmem_req, PCWre, IRWre, RegWre, DataMemRW, ALUSrcB, ExtSel;
   logic [1:0] RegOut;
   logic       ALUM2Reg, WrRegData;
   logic [1:0] PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] state;
   logic       fault, halted;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   int   total = 0;
   int   bad   = 0;
   obs_t exp_q[$];
   string nm_q[$];

   mc_ctrl_fsm dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .opcode     (opcode),
      .zero       (zero),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .PCWre      (PCWre),
      .IRWre      (IRWre),
      .RegWre     (RegWre),
      .DataMemRW  (DataMemRW),
      .ALUSrcB    (ALUSrcB),
      .ExtSel     (ExtSel),
      .RegOut     (RegOut),
      .ALUM2Reg   (ALUM2Reg),
      .WrRegData  (WrRegData),
      .PCSrc      (PCSrc),
      .ALUOp      (ALUOp),
      .state      (state),
      .fault      (fault),
`ifdef MC_PERF_CNT_EN
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt),
`endif
      .halted     (halted)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Monitor: one expectation per cycle, compared at the falling edge.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         obs_t  e;
         obs_t  g;
         string n;
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         g = '{st: state, imem_req: imem_req, dmem_req: dmem_req, pcwre: PCWre, irwre: IRWre,
               regwre: RegWre, memrw: DataMemRW, alusrcb: ALUSrcB, extsel: ExtSel, regout: RegOut,
               alum2reg: ALUM2Reg, wrregdata: WrRegData, pcsrc: PCSrc, aluop: ALUOp,
               fault: fault, halted: halted};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL %s: got st=%b outs=%h, want st=%b outs=%h", n, g.st, g, e.st, e);
         end
      end
   end

   function automatic obs_t z(input logic [3:0] s);
      obs_t o;
      o    = '0;
      o.st = s;
      return o;
   endfunction

   // Drive one cycle of inputs and queue the outputs expected during that cycle.
   task automatic step(input logic ir, input logic dr, input logic [5:0] op, input logic zf,
                       input obs_t e, input string nm);
      imem_ready = ir;
      dmem_ready = dr;
      opcode     = op;
      zero       = zf;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge CLK);
      #1;
   endtask

   // Reset asserted mid-cycle: outputs must already be in reset state before the next edge.
   task automatic do_reset(input string nm);
      Reset      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      exp_q.push_back(z(Q_IF));
      nm_q.push_back(nm);
      @(posedge CLK);
      #1;
      Reset = 1'b1;
   endtask

   task automatic fetch(input logic [5:0] op, input string nm);
      obs_t o;
      o = z(Q_IF); o.imem_req = 1'b1; o.irwre = 1'b1;
      step(1'b1, 1'b0, op, 1'b0, o, nm);
   endtask

   task automatic run_add(input string nm);
      obs_t o;
      fetch(T_ADD, {nm, "_if"});
      step(1'b1, 1'b0, T_ADD, 1'b0, z(Q_ID), {nm, "_id"});
      o = z(Q_EXE_R); o.extsel = 1'b1;
      step(1'b1, 1'b0, T_ADD, 1'b0, o, {nm, "_exe"});
      o = z(Q_WB_R); o.regwre = 1'b1; o.regout = 2'b10; o.wrregdata = 1'b1; o.pcwre = 1'b1;
      step(1'b1, 1'b0, T_ADD, 1'b0, o, {nm, "_wb"});
   endtask

   initial begin
      obs_t o;
      Reset      = 1'b0;
      opcode     = 6'b0;
      zero       = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      @(posedge CLK);
      #1;
      do_reset("reset_state");

      // ADD: IF, ID, EXE_R, WB_R
      run_add("add0");
`ifdef MC_PERF_CNT_EN
      do_reset("perf_reset");
      run_add("add1");
      run_add("add2");
      run_add("add3");
      total++;
      if (instr_cnt !== 32'd3) begin
         bad++;
         $display("FAIL instr_cnt: got %0d, want 3", instr_cnt);
      end
      total++;
      if (cycle_cnt !== 32'd12) begin
         bad++;
         $display("FAIL cycle_cnt: got %0d, want 12", cycle_cnt);
      end
`endif

      // ORI: immediate, zero extend, writes rt
      fetch(T_ORI, "ori_if");
      step(1'b1, 1'b0, T_ORI, 1'b0, z(Q_ID), "ori_id");
      o = z(Q_EXE_R); o.aluop = 3'b011; o.alusrcb = 1'b1;
      step(1'b1, 1'b0, T_ORI, 1'b0, o, "ori_exe");
      o = z(Q_WB_R); o.regwre = 1'b1; o.regout = 2'b01; o.wrregdata = 1'b1; o.pcwre = 1'b1;
      step(1'b1, 1'b0, T_ORI, 1'b0, o, "ori_wb");

      // SLT
      fetch(T_SLT, "slt_if");
      step(1'b1, 1'b0, T_SLT, 1'b0, z(Q_ID), "slt_id");
      o = z(Q_EXE_R); o.aluop = 3'b110; o.extsel = 1'b1;
      step(1'b1, 1'b0, T_SLT, 1'b0, o, "slt_exe");
      o = z(Q_WB_R); o.regwre = 1'b1; o.regout = 2'b10; o.wrregdata = 1'b1; o.pcwre = 1'b1;
      step(1'b1, 1'b0, T_SLT, 1'b0, o, "slt_wb");

      // LW with three wait cycles
      fetch(T_LW, "lw_if");
      step(1'b1, 1'b0, T_LW, 1'b0, z(Q_ID), "lw_id");
      o = z(Q_EXE_LS); o.alusrcb = 1'b1; o.extsel = 1'b1;
      step(1'b1, 1'b0, T_LW, 1'b0, o, "lw_exe");
      o = z(Q_MEM); o.dmem_req = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, T_LW, 1'b0, o, "lw_mem_wait");
      step(1'b1, 1'b1, T_LW, 1'b0, o, "lw_mem_done");
      o = z(Q_WB_LW); o.regwre = 1'b1; o.regout = 2'b01; o.alum2reg = 1'b1;
      o.wrregdata = 1'b1; o.pcwre = 1'b1;
      step(1'b1, 1'b0, T_LW, 1'b0, o, "lw_wb");

      // SW, immediate ready
      fetch(T_SW, "sw_if");
      step(1'b1, 1'b0, T_SW, 1'b0, z(Q_ID), "sw_id");
      o = z(Q_EXE_LS); o.alusrcb = 1'b1; o.extsel = 1'b1;
      step(1'b1, 1'b0, T_SW, 1'b0, o, "sw_exe");
      o = z(Q_MEM); o.dmem_req = 1'b1; o.memrw = 1'b1; o.pcwre = 1'b1;
      step(1'b1, 1'b1, T_SW, 1'b0, o, "sw_mem");

      // BEQ taken and not taken
      fetch(T_BEQ, "beq1_if");
      step(1'b1, 1'b0, T_BEQ, 1'b1, z(Q_ID), "beq1_id");
      o = z(Q_EXE_BR); o.aluop = 3'b001; o.pcwre = 1'b1; o.pcsrc = 2'b01;
      step(1'b1, 1'b0, T_BEQ, 1'b1, o, "beq_taken");
      fetch(T_BEQ, "beq0_if");
      step(1'b1, 1'b0, T_BEQ, 1'b0, z(Q_ID), "beq0_id");
      o = z(Q_EXE_BR); o.aluop = 3'b001; o.pcwre = 1'b1; o.pcsrc = 2'b00;
      step(1'b1, 1'b0, T_BEQ, 1'b0, o, "beq_not_taken");

      // Jumps complete in ID
      fetch(T_J, "j_if");
      o = z(Q_ID); o.pcsrc = 2'b11; o.pcwre = 1'b1;
      step(1'b1, 1'b0, T_J, 1'b0, o, "j_id");
      fetch(T_JR, "jr_if");
      o = z(Q_ID); o.pcsrc = 2'b10; o.pcwre = 1'b1;
      step(1'b1, 1'b0, T_JR, 1'b0, o, "jr_id");
      fetch(T_JAL, "jal_if");
      o = z(Q_ID); o.pcsrc = 2'b11; o.pcwre = 1'b1; o.regwre = 1'b1;
      o.regout = 2'b00; o.wrregdata = 1'b0;
      step(1'b1, 1'b0, T_JAL, 1'b0, o, "jal_id");

      // Ready on the 16th IF cycle still completes the fetch
      o = z(Q_IF); o.imem_req = 1'b1;
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, T_J, 1'b0, o, "if_wait15");
      fetch(T_J, "if_ready_at_limit");
      o = z(Q_ID); o.pcsrc = 2'b11; o.pcwre = 1'b1;
      step(1'b1, 1'b0, T_J, 1'b0, o, "if_limit_j_id");

      // IF timeout: 16 not-ready cycles then sticky FAULT
      o = z(Q_IF); o.imem_req = 1'b1;
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, T_ADD, 1'b0, o, "if_wait16");
      o = z(Q_FAULT); o.fault = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, T_ADD, 1'b0, o, "if_timeout_fault");
      do_reset("fault_reset");

      // MEM timeout
      fetch(T_LW, "lwto_if");
      step(1'b1, 1'b0, T_LW, 1'b0, z(Q_ID), "lwto_id");
      o = z(Q_EXE_LS); o.alusrcb = 1'b1; o.extsel = 1'b1;
      step(1'b1, 1'b0, T_LW, 1'b0, o, "lwto_exe");
      o = z(Q_MEM); o.dmem_req = 1'b1;
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, T_LW, 1'b0, o, "mem_wait16");
      o = z(Q_FAULT); o.fault = 1'b1;
      step(1'b1, 1'b1, T_LW, 1'b0, o, "mem_timeout_fault");
      do_reset("mem_fault_reset");

      // Illegal opcode
      fetch(T_BAD, "bad_if");
      step(1'b1, 1'b0, T_BAD, 1'b0, z(Q_ID), "bad_id");
      o = z(Q_FAULT); o.fault = 1'b1;
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, T_BAD, 1'b0, o, "illegal_fault");
      do_reset("illegal_reset");

      // HALT: no further fetches
      fetch(T_HALT, "halt_if");
      step(1'b1, 1'b0, T_HALT, 1'b0, z(Q_ID), "halt_id");
      o = z(Q_HALT); o.halted = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, T_HALT, 1'b0, o, "halted");
      do_reset("halt_reset");

      // Reset in the middle of a MEM wait
      fetch(T_LW, "lwr_if");
      step(1'b1, 1'b0, T_LW, 1'b0, z(Q_ID), "lwr_id");
      o = z(Q_EXE_LS); o.alusrcb = 1'b1; o.extsel = 1'b1;
      step(1'b1, 1'b0, T_LW, 1'b0, o, "lwr_exe");
      o = z(Q_MEM); o.dmem_req = 1'b1;
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, T_LW, 1'b0, o, "lwr_mem_wait");
      do_reset("reset_mid_mem");

      // Normal operation resumes after reset
      run_add("add_after_reset");

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge CLK);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
